nanorv32_wb_ctrl: RTL and testbench



---
 rtl/nanorv32_wb_ctrl_pkg.sv | 27 ++
 rtl/nanorv32_wb_ldq.sv | 56 +++++
 rtl/nanorv32_wb_ctrl.sv | 148 ++++++++++++++
 tb/tb_nanorv32_wb_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_wb_ctrl_pkg.sv
// Shared constants and types for the writeback controller slice.
package nanorv32_wb_ctrl_pkg;

    // MSB of a register-file port index (5-bit index for 32 registers).
    localparam int NANORV32_RF_PORTRD_MSB = 4;
    localparam int NANORV32_RF_IDX_W      = NANORV32_RF_PORTRD_MSB + 1;

    // Default number of loads that may be outstanding at once.
    localparam int NANORV32_WB_LDQ_DEPTH  = 2;

    // One load-queue entry: destination index plus a flag telling the
    // response path to consume the data without writing the regfile.
    typedef struct packed {
        logic [NANORV32_RF_PORTRD_MSB:0] idx;
        logic                            discard;
    } ldq_entry_t;

    localparam int NANORV32_WB_LDQ_ENTRY_W = $bits(ldq_entry_t);

    // A register index is live unless it is x0 and x0 is not being used
    // as an ordinary register by the micro-ROM.
    function automatic logic zok(input logic [NANORV32_RF_PORTRD_MSB:0] x,
                                 input logic                            allow_x0);
        return (x != '0) || allow_x0;
    endfunction

endpackage

// File: rtl/nanorv32_wb_ldq.sv
// Generic synchronous FIFO with asynchronous active-low reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module nanorv32_wb_ldq #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Entry storage; the caller guarantees push only when not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nanorv32_wb_ctrl.sv
// Writeback controller: one-cycle ALU writeback on port 1, in-order load
// returns on port 2, and a pending-register scoreboard driving hazard_stall.
module nanorv32_wb_ctrl
    import nanorv32_wb_ctrl_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = NANORV32_WB_LDQ_DEPTH,
    parameter int NUM_REGS      = 32,
    parameter int DATA_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  ld_issue,
    input  logic [4:0]            ld_rd,
    output logic                  ld_ready,
    input  logic                  ld_resp_valid,
    input  logic [DATA_W-1:0]     ld_resp_data,
    input  logic [4:0]            rs1_sel,
    input  logic [4:0]            rs2_sel,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic                  allow_hidden_use_of_x0,
    output logic [4:0]            sel_rd,
    output logic [4:0]            sel_rd2,
    output logic [DATA_W-1:0]     rd,
    output logic [DATA_W-1:0]     rd2,
    output logic                  write_rd,
    output logic                  write_rd2,
    output logic                  hazard_stall,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  ld_resp_err
);

    localparam int CNT_W = $clog2(LD_FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]                   ldq_count;
    logic [NANORV32_WB_LDQ_ENTRY_W-1:0] ldq_head_raw;
    ldq_entry_t                         ldq_head;
    ldq_entry_t                         ldq_push_entry;
    logic                               ldq_pop;
    logic                               ld_acc;
    logic                               alu_acc;
    logic                               ld_discard;
    logic [NUM_REGS-1:0]                mask_next;

    logic rs1_busy, rs2_busy, alu_ldbusy, ld_ldbusy;

    assign ldq_head   = ldq_head_raw;
    assign ld_discard = !zok(ld_rd, allow_hidden_use_of_x0);

    assign ld_ready = (ldq_count != CNT_W'(LD_FIFO_DEPTH));
    assign alu_acc  = alu_valid && !hazard_stall;
    assign ld_acc   = ld_issue && ld_ready && !hazard_stall;
    assign ldq_pop  = ld_resp_valid && (ldq_count != '0);

    assign ldq_push_entry.idx     = ld_rd;
    assign ldq_push_entry.discard = ld_discard;

    // Scoreboard lookups: sources also collide with either writeback port in flight.
    always_comb begin
        rs1_busy   = pending_mask[rs1_sel]
                   | (write_rd  && (sel_rd  == rs1_sel))
                   | (write_rd2 && (sel_rd2 == rs1_sel));
        rs2_busy   = pending_mask[rs2_sel]
                   | (write_rd  && (sel_rd  == rs2_sel))
                   | (write_rd2 && (sel_rd2 == rs2_sel));
        alu_ldbusy = pending_mask[alu_rd];
        ld_ldbusy  = pending_mask[ld_rd];
    end

    // Decode hold for RAW on either source and WAW against an outstanding load.
    always_comb begin
        hazard_stall = (rs1_used  && zok(rs1_sel, allow_hidden_use_of_x0) && rs1_busy)
                     | (rs2_used  && zok(rs2_sel, allow_hidden_use_of_x0) && rs2_busy)
                     | (alu_valid && zok(alu_rd,  allow_hidden_use_of_x0) && alu_ldbusy)
                     | (ld_issue  && zok(ld_rd,   allow_hidden_use_of_x0) && ld_ldbusy);
    end

    // Next pending mask: clear the retiring load first so a same-bit set wins.
    always_comb begin
        mask_next = pending_mask;
        if (ldq_pop) begin
            mask_next[ldq_head.idx] = 1'b0;
        end
        if (ld_acc && !ld_discard) begin
            mask_next[ld_rd] = 1'b1;
        end
    end

    nanorv32_wb_ldq #(
        .DEPTH (LD_FIFO_DEPTH),
        .WIDTH (NANORV32_WB_LDQ_ENTRY_W)
    ) u_ldq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_acc),
        .push_data (ldq_push_entry),
        .pop       (ldq_pop),
        .head      (ldq_head_raw),
        .count     (ldq_count)
    );

    // Port 1: ALU results registered for one cycle; index/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rd   <= '0;
            rd       <= '0;
            write_rd <= 1'b0;
        end else if (alu_acc) begin
            sel_rd   <= alu_rd;
            rd       <= alu_data;
            write_rd <= zok(alu_rd, allow_hidden_use_of_x0);
        end else begin
            write_rd <= 1'b0;
        end
    end

    // Port 2: load data matched against the queue head in issue order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_rd2   <= '0;
            rd2       <= '0;
            write_rd2 <= 1'b0;
        end else if (ldq_pop) begin
            sel_rd2   <= ldq_head.idx;
            rd2       <= ld_resp_data;
            write_rd2 <= !ldq_head.discard;
        end else begin
            write_rd2 <= 1'b0;
        end
    end

    // Scoreboard state and sticky error for responses with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_mask <= '0;
            ld_resp_err  <= 1'b0;
        end else begin
            pending_mask <= mask_next;
            if (ld_resp_valid && (ldq_count == '0)) begin
                ld_resp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nanorv32_wb_ctrl.sv
// Self-checking bench for nanorv32_wb_ctrl with a queue-based reference model.
module tb_nanorv32_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic [4:0]  rs1_sel, rs2_sel;
    logic        rs1_used, rs2_used;
    logic        allow_hidden_use_of_x0;
    logic [4:0]  sel_rd, sel_rd2;
    logic [31:0] rd, rd2;
    logic        write_rd, write_rd2;
    logic        hazard_stall;
    logic [31:0] pending_mask;
    logic        ld_resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nanorv32_wb_ctrl #(
        .LD_FIFO_DEPTH (2),
        .NUM_REGS      (32),
        .DATA_W        (32)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .alu_valid              (alu_valid),
        .alu_rd                 (alu_rd),
        .alu_data               (alu_data),
        .ld_issue               (ld_issue),
        .ld_rd                  (ld_rd),
        .ld_ready               (ld_ready),
        .ld_resp_valid          (ld_resp_valid),
        .ld_resp_data           (ld_resp_data),
        .rs1_sel                (rs1_sel),
        .rs2_sel                (rs2_sel),
        .rs1_used               (rs1_used),
        .rs2_used               (rs2_used),
        .allow_hidden_use_of_x0 (allow_hidden_use_of_x0),
        .sel_rd                 (sel_rd),
        .sel_rd2                (sel_rd2),
        .rd                     (rd),
        .rd2                    (rd2),
        .write_rd               (write_rd),
        .write_rd2              (write_rd2),
        .hazard_stall           (hazard_stall),
        .pending_mask           (pending_mask),
        .ld_resp_err            (ld_resp_err)
    );

    // Reference model: outstanding loads as a queue, writeback ports as plain state.
    int          q_idx[$];
    bit          q_disc[$];
    bit          m_w1, m_w2, m_err;
    logic [4:0]  m_s1, m_s2;
    logic [31:0] m_d1, m_d2;

    function automatic bit m_zok(input logic [4:0] x);
        return (x != 5'd0) || allow_hidden_use_of_x0;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] mk = '0;
        foreach (q_idx[i]) begin
            if (!q_disc[i]) mk = mk | (32'd1 << q_idx[i]);
        end
        return mk;
    endfunction

    function automatic bit m_busy(input logic [4:0] x);
        logic [31:0] mk = m_mask();
        return mk[x] || (m_w1 && m_s1 == x) || (m_w2 && m_s2 == x);
    endfunction

    function automatic bit m_ldbusy(input logic [4:0] x);
        logic [31:0] mk = m_mask();
        return mk[x];
    endfunction

    function automatic bit m_ready();
        return q_idx.size() < 2;
    endfunction

    function automatic bit m_stall();
        return (rs1_used  && m_zok(rs1_sel) && m_busy(rs1_sel))
            || (rs2_used  && m_zok(rs2_sel) && m_busy(rs2_sel))
            || (alu_valid && m_zok(alu_rd)  && m_ldbusy(alu_rd))
            || (ld_issue  && m_zok(ld_rd)   && m_ldbusy(ld_rd));
    endfunction

    task automatic m_reset();
        q_idx.delete();
        q_disc.delete();
        m_w1 = 0; m_w2 = 0; m_err = 0;
        m_s1 = '0; m_s2 = '0; m_d1 = '0; m_d2 = '0;
    endtask

    task automatic m_advance();
        bit stall = m_stall();
        bit had   = q_idx.size() > 0;
        bit push  = ld_issue && m_ready() && !stall;
        if (ld_resp_valid && had) begin
            m_s2 = 5'(q_idx.pop_front());
            m_w2 = !q_disc.pop_front();
            m_d2 = ld_resp_data;
        end else begin
            m_w2 = 0;
            if (ld_resp_valid) m_err = 1;
        end
        if (push) begin
            q_idx.push_back(int'(ld_rd));
            q_disc.push_back(!m_zok(ld_rd));
        end
        if (alu_valid && !stall) begin
            m_w1 = m_zok(alu_rd); m_s1 = alu_rd; m_d1 = alu_data;
        end else begin
            m_w1 = 0;
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        ld_issue = 0; ld_rd = '0;
        ld_resp_valid = 0; ld_resp_data = '0;
        rs1_sel = '0; rs2_sel = '0; rs1_used = 0; rs2_used = 0;
    endtask

    task automatic tick();
        m_advance();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        allow_hidden_use_of_x0 = 0;
        rst_n = 0;
        m_reset();
        #2;
        total++; if (write_rd !== 1'b0 || write_rd2 !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b%b want 00", write_rd, write_rd2); end
        total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
        total++; if (ld_ready !== 1'b1 || ld_resp_err !== 1'b0) begin bad++; $display("FAIL reset_ready_err: got %b%b want 10", ld_ready, ld_resp_err); end
        total++; if (sel_rd !== 5'd0 || rd !== 32'd0 || sel_rd2 !== 5'd0 || rd2 !== 32'd0) begin bad++; $display("FAIL reset_data: got %0d %h %0d %h want zeros", sel_rd, rd, sel_rd2, rd2); end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL alu_nostall: got %b want 0", hazard_stall); end
        tick();
        total++; if (write_rd !== 1'b1 || sel_rd !== 5'd5 || rd !== 32'h1234) begin bad++; $display("FAIL alu_write: got %b %0d %h want 1 5 1234", write_rd, sel_rd, rd); end
        rs1_used = 1; rs1_sel = 5'd5;
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL alu_wb_hit: got %b want 1", hazard_stall); end
        tick();
        rs1_used = 1; rs1_sel = 5'd5;
        #1;
        total++; if (write_rd !== 1'b0 || hazard_stall !== 1'b0) begin bad++; $display("FAIL alu_retired: got wr=%b stall=%b want 0 0", write_rd, hazard_stall); end
        tick();
    endtask

    task automatic test_load_raw();
        ld_issue = 1; ld_rd = 5'd7;
        tick();
        rs2_used = 1; rs2_sel = 5'd7;
        #1;
        total++; if (pending_mask !== 32'h80 || hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_pending: got mask=%h stall=%b want 80 1", pending_mask, hazard_stall); end
        tick();
        rs2_used = 1; rs2_sel = 5'd7; ld_resp_valid = 1; ld_resp_data = 32'hDEAD;
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_resp_stall: got %b want 1", hazard_stall); end
        tick();
        rs2_used = 1; rs2_sel = 5'd7;
        #1;
        total++; if (write_rd2 !== 1'b1 || sel_rd2 !== 5'd7 || rd2 !== 32'hDEAD || pending_mask !== 32'd0) begin bad++; $display("FAIL raw_ret: got %b %0d %h %h want 1 7 dead 0", write_rd2, sel_rd2, rd2, pending_mask); end
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_wb2_stall: got %b want 1", hazard_stall); end
        tick();
        rs2_used = 1; rs2_sel = 5'd7;
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_clear: got %b want 0", hazard_stall); end
        tick();
    endtask

    task automatic test_fifo_wrap();
        ld_issue = 1; ld_rd = 5'd3; tick();
        ld_issue = 1; ld_rd = 5'd4; tick();
        ld_issue = 1; ld_rd = 5'd12;
        #1;
        total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", ld_ready); end
        tick();
        total++; if (pending_mask !== 32'h18) begin bad++; $display("FAIL full_ignored: got %h want 18", pending_mask); end
        ld_resp_valid = 1; ld_resp_data = 32'hAAAA; tick();
        total++; if (write_rd2 !== 1'b1 || sel_rd2 !== 5'd3 || rd2 !== 32'hAAAA) begin bad++; $display("FAIL order_a: got %b %0d %h want 1 3 aaaa", write_rd2, sel_rd2, rd2); end
        ld_resp_valid = 1; ld_resp_data = 32'hBBBB; tick();
        total++; if (sel_rd2 !== 5'd4 || rd2 !== 32'hBBBB || pending_mask !== 32'd0) begin bad++; $display("FAIL order_b: got %0d %h %h want 4 bbbb 0", sel_rd2, rd2, pending_mask); end
        ld_issue = 1; ld_rd = 5'd9; tick();
        ld_issue = 1; ld_rd = 5'd11; ld_resp_valid = 1; ld_resp_data = 32'hCCCC; tick();
        total++; if (write_rd2 !== 1'b1 || sel_rd2 !== 5'd9 || pending_mask !== 32'h800 || ld_ready !== 1'b1) begin bad++; $display("FAIL pushpop: got %b %0d %h rdy=%b want 1 9 800 1", write_rd2, sel_rd2, pending_mask, ld_ready); end
        ld_resp_valid = 1; ld_resp_data = 32'hDDDD; tick();
        total++; if (sel_rd2 !== 5'd11 || rd2 !== 32'hDDDD || pending_mask !== 32'd0) begin bad++; $display("FAIL wrap_order: got %0d %h %h want 11 dddd 0", sel_rd2, rd2, pending_mask); end
    endtask

    task automatic test_waw();
        ld_issue = 1; ld_rd = 5'd10; tick();
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h5555;
        #1;
        total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL waw_stall: got %b want 1", hazard_stall); end
        tick();
        total++; if (write_rd !== 1'b0) begin bad++; $display("FAIL waw_nowrite: got %b want 0", write_rd); end
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h5555; ld_resp_valid = 1; ld_resp_data = 32'h7777;
        tick();
        total++; if (write_rd !== 1'b0 || write_rd2 !== 1'b1 || sel_rd2 !== 5'd10) begin bad++; $display("FAIL waw_ret: got %b %b %0d want 0 1 10", write_rd, write_rd2, sel_rd2); end
        alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h5555;
        #1;
        total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL waw_release: got %b want 0", hazard_stall); end
        tick();
        total++; if (write_rd !== 1'b1 || sel_rd !== 5'd10 || rd !== 32'h5555) begin bad++; $display("FAIL waw_alu: got %b %0d %h want 1 10 5555", write_rd, sel_rd, rd); end
    endtask

    task automatic test_x0();
        allow_hidden_use_of_x0 = 0;
        ld_issue = 1; ld_rd = 5'd0; tick();
        total++; if (pending_mask !== 32'd0) begin bad++; $display("FAIL x0_nomask: got %h want 0", pending_mask); end
        ld_resp_valid = 1; ld_resp_data = 32'h0F0F; tick();
        total++; if (write_rd2 !== 1'b0 || ld_resp_err !== 1'b0) begin bad++; $display("FAIL x0_discard: got wr2=%b err=%b want 0 0", write_rd2, ld_resp_err); end
        allow_hidden_use_of_x0 = 1;
        ld_issue = 1; ld_rd = 5'd0; tick();
        total++; if (pending_mask !== 32'd1) begin bad++; $display("FAIL x0_mask: got %h want 1", pending_mask); end
        ld_resp_valid = 1; ld_resp_data = 32'hF0F0; tick();
        total++; if (write_rd2 !== 1'b1 || sel_rd2 !== 5'd0 || rd2 !== 32'hF0F0) begin bad++; $display("FAIL x0_write: got %b %0d %h want 1 0 f0f0", write_rd2, sel_rd2, rd2); end
        allow_hidden_use_of_x0 = 0;
    endtask

    task automatic test_err_reset();
        ld_resp_valid = 1; ld_resp_data = 32'h1; tick();
        total++; if (ld_resp_err !== 1'b1 || write_rd2 !== 1'b0) begin bad++; $display("FAIL err_set: got err=%b wr2=%b want 1 0", ld_resp_err, write_rd2); end
        tick();
        total++; if (ld_resp_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", ld_resp_err); end
        ld_issue = 1; ld_rd = 5'd1; tick();
        ld_issue = 1; ld_rd = 5'd2; tick();
        #2;
        rst_n = 0;
        m_reset();
        #1;
        total++; if (pending_mask !== 32'd0 || ld_ready !== 1'b1 || ld_resp_err !== 1'b0) begin bad++; $display("FAIL async_reset: got mask=%h rdy=%b err=%b want 0 1 0", pending_mask, ld_ready, ld_resp_err); end
        #1;
        rst_n = 1;
        ld_resp_valid = 1; ld_resp_data = 32'h2; tick();
        total++; if (ld_resp_err !== 1'b1 || write_rd2 !== 1'b0) begin bad++; $display("FAIL reset_drops: got err=%b wr2=%b want 1 0", ld_resp_err, write_rd2); end
    endtask

    task automatic test_random(input bit allow);
        rst_n = 0;
        idle();
        m_reset();
        #2;
        rst_n = 1;
        allow_hidden_use_of_x0 = allow;
        for (int n = 0; n < 400; n++) begin
            alu_valid     = ($urandom_range(1) == 0);
            alu_rd        = 5'($urandom_range(7));
            alu_data      = $urandom;
            ld_issue      = ($urandom_range(2) == 0);
            ld_rd         = 5'($urandom_range(7));
            ld_resp_valid = ($urandom_range(2) == 0);
            ld_resp_data  = $urandom;
            rs1_used      = ($urandom_range(1) == 0);
            rs1_sel       = 5'($urandom_range(7));
            rs2_used      = ($urandom_range(2) == 0);
            rs2_sel       = 5'($urandom_range(7));
            #1;
            total++; if (hazard_stall !== m_stall()) begin bad++; $display("FAIL rnd_stall @%0d: got %b want %b", n, hazard_stall, m_stall()); end
            total++; if (ld_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready @%0d: got %b want %b", n, ld_ready, m_ready()); end
            tick();
            total++; if (write_rd !== m_w1 || sel_rd !== m_s1 || rd !== m_d1) begin bad++; $display("FAIL rnd_port1 @%0d: got %b %0d %h want %b %0d %h", n, write_rd, sel_rd, rd, m_w1, m_s1, m_d1); end
            total++; if (write_rd2 !== m_w2 || sel_rd2 !== m_s2 || rd2 !== m_d2) begin bad++; $display("FAIL rnd_port2 @%0d: got %b %0d %h want %b %0d %h", n, write_rd2, sel_rd2, rd2, m_w2, m_s2, m_d2); end
            total++; if (pending_mask !== m_mask() || ld_resp_err !== m_err) begin bad++; $display("FAIL rnd_mask_err @%0d: got %h %b want %h %b", n, pending_mask, ld_resp_err, m_mask(), m_err); end
        end
        allow_hidden_use_of_x0 = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_raw();
        test_fifo_wrap();
        test_waw();
        test_x0();
        test_err_reset();
        test_random(1'b0);
        test_random(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
